var_delay_line: RTL and testbench

VAR_DELAY_LINE -- requirements
Module: var_delay_line

---
 rtl/var_delay_line.sv | 150 +++++++++++++++
 tb/tb_var_delay_line.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/var_delay_line.sv
// Variable-depth delay line: MaxDepth {valid,data} stages with a registered, clamped tap select.
// Optional bypass when depth_i==0 is enabled by defining VAR_DELAY_BYPASS_EN.
module var_delay_line #(
  parameter int Width    = 32,
  parameter int MaxDepth = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          en_i,
  input  logic                          flush_i,
  input  logic [$clog2(MaxDepth+1)-1:0] depth_i,
  input  logic                          valid_i,
  input  logic [Width-1:0]              d_i,
  output logic [Width-1:0]              d_o,
  output logic                          valid_o,
  output logic                          primed_o
);

  localparam int DepthW = $clog2(MaxDepth + 1);
  localparam int IdxW   = $clog2(MaxDepth);
  localparam logic [DepthW-1:0] MaxDepthW = DepthW'(MaxDepth);
  localparam logic [DepthW-1:0] OneW      = DepthW'(1);

  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

  state_t            state_reg, state_next;
  logic [DepthW-1:0] depth_reg, depth_clamped;
  logic [DepthW-1:0] fill_cnt_reg, fill_cnt_next, fill_inc;
  logic              depth_change;
  logic [IdxW-1:0]   tap_idx;
  logic [Width-1:0]  data_reg  [MaxDepth];
  logic              valid_reg [MaxDepth];

  always_comb begin
    depth_clamped = depth_i;
    if (depth_i > MaxDepthW) begin
      depth_clamped = MaxDepthW;
    end else if (depth_i == '0) begin
      depth_clamped = OneW;
    end
  end

`ifdef VAR_DELAY_BYPASS_EN
  logic bypass;
  logic bypass_reg;

  assign bypass = (depth_i == '0);

  // Bypass runs the line at depth 1 underneath, so leaving it must force a refill.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bypass_reg <= 1'b0;
    end else begin
      bypass_reg <= bypass;
    end
  end

  assign depth_change = (depth_clamped != depth_reg) || (bypass_reg && !bypass);
`else
  assign depth_change = (depth_clamped != depth_reg);
`endif

  assign fill_inc = (fill_cnt_reg == MaxDepthW) ? fill_cnt_reg : fill_cnt_reg + OneW;

  // Priority: flush, then depth change, then ordinary enabled shift.
  always_comb begin
    state_next    = state_reg;
    fill_cnt_next = fill_cnt_reg;
    if (flush_i) begin
      state_next    = IDLE;
      fill_cnt_next = '0;
    end else if (depth_change) begin
      fill_cnt_next = DepthW'(en_i);
      state_next    = (en_i && depth_clamped == OneW) ? RUN : FILL;
    end else if (en_i) begin
      case (state_reg)
        IDLE: begin
          fill_cnt_next = OneW;
          state_next    = (depth_reg == OneW) ? RUN : FILL;
        end
        FILL: begin
          fill_cnt_next = fill_inc;
          if (fill_inc >= depth_reg) state_next = RUN;
        end
        RUN:     fill_cnt_next = fill_inc;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg    <= IDLE;
      fill_cnt_reg <= '0;
      depth_reg    <= MaxDepthW;
    end else begin
      state_reg    <= state_next;
      fill_cnt_reg <= fill_cnt_next;
      depth_reg    <= depth_clamped;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < MaxDepth; gi++) begin : g_stage
      localparam bit IsHead = (gi == 0);
      logic [Width-1:0] src_data;
      logic             src_valid;

      if (gi == 0) begin : g_head
        assign src_data  = d_i;
        assign src_valid = valid_i;
      end else begin : g_tail
        assign src_data  = data_reg[gi-1];
        assign src_valid = valid_reg[gi-1];
      end

      // A depth change invalidates stored samples but keeps their data.
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          data_reg[gi]  <= '0;
          valid_reg[gi] <= 1'b0;
        end else if (flush_i) begin
          data_reg[gi]  <= '0;
          valid_reg[gi] <= 1'b0;
        end else begin
          if (en_i) data_reg[gi] <= src_data;
          if (depth_change) begin
            valid_reg[gi] <= IsHead && en_i && valid_i;
          end else if (en_i) begin
            valid_reg[gi] <= src_valid;
          end
        end
      end
    end
  endgenerate

  assign tap_idx = IdxW'(depth_reg - OneW);

`ifdef VAR_DELAY_BYPASS_EN
  assign d_o      = bypass ? d_i : data_reg[tap_idx];
  assign valid_o  = bypass ? valid_i : (valid_reg[tap_idx] && (state_reg == RUN));
  assign primed_o = bypass || (state_reg == RUN);
`else
  assign d_o      = data_reg[tap_idx];
  assign valid_o  = valid_reg[tap_idx] && (state_reg == RUN);
  assign primed_o = (state_reg == RUN);
`endif

endmodule

// File: tb/tb_var_delay_line.sv
// Directed bench for var_delay_line (Width=32, MaxDepth=8) with hand-computed expectations.
// Expectations for the depth_i==0 case follow VAR_DELAY_BYPASS_EN.
module tb_var_delay_line;

  logic        clk_i;
  logic        rst_ni;
  logic        en_i;
  logic        flush_i;
  logic [3:0]  depth_i;
  logic        valid_i;
  logic [31:0] d_i;
  logic [31:0] d_o;
  logic        valid_o;
  logic        primed_o;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  var_delay_line #(
    .Width    (32),
    .MaxDepth (8)
  ) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .en_i     (en_i),
    .flush_i  (flush_i),
    .depth_i  (depth_i),
    .valid_i  (valid_i),
    .d_i      (d_i),
    .d_o      (d_o),
    .valid_o  (valid_o),
    .primed_o (primed_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
    cyc++;
    $display("cyc %0d: en=%0b flush=%0b depth=%0d v_i=%0b d_i=0x%08h -> d_o=0x%08h valid_o=%0b primed_o=%0b",
             cyc, en_i, flush_i, depth_i, valid_i, d_i, d_o, valid_o, primed_o);
  endtask

  task automatic check_out(input string tag, input logic [31:0] ed, input logic ev, input logic ep);
    check({tag, ".d_o"}, d_o, ed);
    check({tag, ".valid_o"}, {31'd0, valid_o}, {31'd0, ev});
    check({tag, ".primed_o"}, {31'd0, primed_o}, {31'd0, ep});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_d;
    rst_ni  = 1'b0;
    en_i    = 1'b0;
    flush_i = 1'b0;
    depth_i = 4'd8;
    valid_i = 1'b0;
    d_i     = 32'd0;
    repeat (2) step();
    check_out("reset", 32'd0, 1'b0, 1'b0);
    rst_ni = 1'b1;

    // Full depth 8: samples 1..8 then zeros
    en_i    = 1'b1;
    valid_i = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      d_i = (i <= 8) ? 32'(i) : 32'd0;
      step();
      if (i < 8) begin
        check("fill8.primed_o", {31'd0, primed_o}, 32'd0);
      end else begin
        exp_d = (i - 7 <= 8) ? 32'(i - 7) : 32'd0;
        check_out("run8", exp_d, 1'b1, 1'b1);
      end
    end

    // Out-of-range depth clamps to 8: no refill
    depth_i = 4'd15;
    d_i     = 32'd0;
    repeat (2) begin
      step();
      check_out("clamp15", 32'd0, 1'b1, 1'b1);
    end

    // Depth change 8 -> 3
    depth_i = 4'd3;
    d_i = 32'd101; step(); check_out("chg3.e1", 32'd0, 1'b0, 1'b0);
    d_i = 32'd102; step(); check("chg3.e2.primed_o", {31'd0, primed_o}, 32'd0);
    check("chg3.e2.valid_o", {31'd0, valid_o}, 32'd0);
    d_i = 32'd103; step(); check_out("chg3.e3", 32'd101, 1'b1, 1'b1);
    d_i = 32'd104; step(); check_out("chg3.e4", 32'd102, 1'b1, 1'b1);

    // Flush with en_i=1 while running
    flush_i = 1'b1;
    d_i     = 32'd200;
    step();
    check_out("flush", 32'd0, 1'b0, 1'b0);
    flush_i = 1'b0;

    // Depth 3 stream with a 3-cycle stall holding sample 4
    d_i = 32'd1; step(); check_out("s3.e1", 32'd0, 1'b0, 1'b0);
    d_i = 32'd2; step(); check("s3.e2.primed_o", {31'd0, primed_o}, 32'd0);
    d_i = 32'd3; step(); check_out("s3.e3", 32'd1, 1'b1, 1'b1);
    en_i = 1'b0;
    d_i  = 32'd4;
    repeat (3) begin
      step();
      check_out("stall", 32'd1, 1'b1, 1'b1);
    end
    en_i = 1'b1;
    d_i = 32'd4; step(); check_out("resume.4", 32'd2, 1'b1, 1'b1);
    d_i = 32'd5; step(); check_out("resume.5", 32'd3, 1'b1, 1'b1);
    d_i = 32'd6; step(); check_out("resume.6", 32'd4, 1'b1, 1'b1);

    // Invalid sample travels with valid_o=0
    d_i = 32'd7; valid_i = 1'b0; step(); check_out("inv.e1", 32'd5, 1'b1, 1'b1);
    d_i = 32'd8; valid_i = 1'b1; step(); check_out("inv.e2", 32'd6, 1'b1, 1'b1);
    d_i = 32'd9;                 step(); check_out("inv.e3", 32'd7, 1'b0, 1'b1);

    // Asynchronous reset pulse between edges
    d_i = 32'd10;
    #2;
    rst_ni = 1'b0;
    #1;
    check_out("async_rst", 32'd0, 1'b0, 1'b0);
    rst_ni = 1'b1;
    d_i = 32'd50; step(); check_out("refill.e1", 32'd0, 1'b0, 1'b0);
    d_i = 32'd51; step(); check("refill.e2.primed_o", {31'd0, primed_o}, 32'd0);
    d_i = 32'd52; step(); check_out("refill.e3", 32'd50, 1'b1, 1'b1);

    // depth_i = 0
    depth_i = 4'd0;
    d_i     = 32'hA5A5_A5A5;
`ifdef VAR_DELAY_BYPASS_EN
    #1;
    check_out("bypass.comb", 32'hA5A5_A5A5, 1'b1, 1'b1);
    step();
    d_i = 32'h5A5A_5A5A;
    #1;
    check_out("bypass.comb2", 32'h5A5A_5A5A, 1'b1, 1'b1);
`else
    step();
    check_out("depth0.e1", 32'hA5A5_A5A5, 1'b1, 1'b1);
    d_i = 32'h5A5A_5A5A;
    step();
    check_out("depth0.e2", 32'h5A5A_5A5A, 1'b1, 1'b1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
